spk_out_gen: RTL and testbench

- Transmit-side counterpart of the axon input stage. Turns per-neuron fire results from the soma into SPIKE packets carrying (x,y,z) coordinates, in the same packing the axon decodes.
- On request, streams soma memory out as DATA ... DATA_END packets, the inverse of the axon INPUT write path.
- Sits between soma and the node's spike-out router port.
- Spike coordinates are buffered in a small FIFO so the router can stall without losing fires.

---
 rtl/spk_out_gen.sv | 129 ++++++++++++
 tb/tb_spk_out_gen.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/spk_out_gen.sv
// spk_out_gen: turns soma fire results into SPIKE packets and streams soma memory as DATA/DATA_END.
// Optional SPK_OUT_PKT_CNT_EN adds a saturating SPIKE transfer counter on port spk_cnt.
module spk_out_gen #(
    parameter int NNW = 12,
    parameter int SW  = 24,
    parameter int FTW = 3,
    parameter int FD  = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           scan_vld,
    input  logic           scan_fire,
    input  logic           scan_last,
    output logic           scan_rdy,
    input  logic [NNW-1:0] x_out,
    input  logic [NNW-1:0] y_out,
    input  logic           rd_req,
    input  logic [NNW-1:0] rd_len,
    output logic           soma_rd_en,
    output logic [NNW-1:0] soma_rd_addr,
    input  logic [SW-1:0]  soma_rd_data,
    output logic           spk_out_vld,
    output logic [SW-1:0]  spk_out_data,
    output logic [FTW-1:0] spk_out_type,
    input  logic           spk_out_rdy,
    output logic           busy
`ifdef SPK_OUT_PKT_CNT_EN
    ,
    output logic [31:0]    spk_cnt
`endif
);
    localparam int FW = SW / 3;
    localparam logic [NNW-1:0] ONE = 1;
    localparam logic [FTW-1:0] T_SPIKE = 0, T_DATA = 1, T_END = 2;

    typedef enum logic [2:0] {IDLE, DRAIN, RD, CAP, TX} state_t;
    state_t state, nxt;

    logic [SW-1:0]  mem [1<<FD];
    logic [FD-1:0]  wp, rp;
    logic [FD:0]    cnt;
    logic [NNW-1:0] xc, yc, zc, rem, addr;
    logic [SW-1:0]  data_r;
    logic [FTW-1:0] type_r;
    logic           empty, full, acc, push, pop, spike_vld, xw, yw;

    assign empty     = cnt == '0;
    assign full      = cnt[FD];
    assign scan_rdy  = state == IDLE && !full;
    assign acc       = scan_vld && scan_rdy;
    assign push      = acc && scan_fire;
    assign spike_vld = (state == IDLE || state == DRAIN) && !empty;
    assign pop       = spike_vld && spk_out_rdy;
    assign xw        = xc == x_out - ONE;
    assign yw        = yc == y_out - ONE;

    assign spk_out_vld  = state == TX || spike_vld;
    assign spk_out_data = state == TX ? data_r : spike_vld ? mem[rp] : '0;
    assign spk_out_type = state == TX ? type_r : T_SPIKE;
    assign soma_rd_en   = state == RD;
    assign soma_rd_addr = addr;
    assign busy         = state != IDLE || !empty;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = rd_req ? DRAIN : IDLE;
            DRAIN:   nxt = empty ? RD : DRAIN;
            RD:      nxt = CAP;
            CAP:     nxt = TX;
            TX:      nxt = spk_out_rdy ? (rem == ONE ? IDLE : RD) : TX;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rem    <= '0;
            addr   <= '0;
            data_r <= '0;
            type_r <= '0;
        end else begin
            if (state == IDLE && rd_req) begin
                rem  <= rd_len == '0 ? ONE : rd_len;
                addr <= '0;
            end
            if (state == CAP) begin
                data_r <= soma_rd_data;
                type_r <= rem == ONE ? T_END : T_DATA;
            end
            if (state == TX && spk_out_rdy) begin
                rem  <= rem - ONE;
                addr <= addr + ONE;
            end
        end

    // Entries are written before the counters advance, so each holds the fired neuron's own coordinates
    always_ff @(posedge clk)
        if (push) mem[wp] <= {zc[FW-1:0], yc[FW-1:0], xc[FW-1:0]};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
            xc  <= '0;
            yc  <= '0;
            zc  <= '0;
        end else begin
            wp  <= push ? wp + 1'b1 : wp;
            rp  <= pop ? rp + 1'b1 : rp;
            cnt <= cnt + (FD+1)'(push) - (FD+1)'(pop);
            if (acc) begin
                xc <= scan_last || xw ? '0 : xc + ONE;
                yc <= scan_last || (xw && yw) ? '0 : xw ? yc + ONE : yc;
                zc <= scan_last ? '0 : xw && yw ? zc + ONE : zc;
            end
        end

`ifdef SPK_OUT_PKT_CNT_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)                     spk_cnt <= '0;
        else if (pop && spk_cnt != '1)  spk_cnt <= spk_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_spk_out_gen.sv
// tb_spk_out_gen: directed self-checking bench for spk_out_gen spike and dump paths.
module tb_spk_out_gen;
    localparam int NNW = 12, SW = 24, FTW = 3;

    logic           clk = 0, rst_n = 1;
    logic           scan_vld = 0, scan_fire = 0, scan_last = 0, scan_rdy;
    logic [NNW-1:0] x_out = 4, y_out = 4;
    logic           rd_req = 0;
    logic [NNW-1:0] rd_len = 0;
    logic           soma_rd_en;
    logic [NNW-1:0] soma_rd_addr;
    logic [SW-1:0]  soma_rd_data = 0;
    logic           spk_out_vld;
    logic [SW-1:0]  spk_out_data;
    logic [FTW-1:0] spk_out_type;
    logic           spk_out_rdy = 1;
    logic           busy;
`ifdef SPK_OUT_PKT_CNT_EN
    logic [31:0]    spk_cnt;
`endif

    int total = 0, pass = 0, cyc = 0;
    logic [SW-1:0]  pd [$];
    logic [FTW-1:0] pt [$];
    int             pc [$];
    logic [NNW-1:0] ra [$];
    int             rc [$];

    spk_out_gen dut (
        .clk(clk), .rst_n(rst_n),
        .scan_vld(scan_vld), .scan_fire(scan_fire), .scan_last(scan_last), .scan_rdy(scan_rdy),
        .x_out(x_out), .y_out(y_out),
        .rd_req(rd_req), .rd_len(rd_len),
        .soma_rd_en(soma_rd_en), .soma_rd_addr(soma_rd_addr), .soma_rd_data(soma_rd_data),
        .spk_out_vld(spk_out_vld), .spk_out_data(spk_out_data), .spk_out_type(spk_out_type),
        .spk_out_rdy(spk_out_rdy), .busy(busy)
`ifdef SPK_OUT_PKT_CNT_EN
        , .spk_cnt(spk_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Soma memory holds mem[i] = i + 24'h100, one-cycle read latency
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && spk_out_vld && spk_out_rdy) begin
            pd.push_back(spk_out_data);
            pt.push_back(spk_out_type);
            pc.push_back(cyc);
        end
        if (soma_rd_en) begin
            ra.push_back(soma_rd_addr);
            rc.push_back(cyc);
            soma_rd_data <= 24'h100 + 24'(soma_rd_addr);
        end
    end

    task automatic clear_log();
        pd.delete(); pt.delete(); pc.delete(); ra.delete(); rc.delete();
    endtask

    task automatic send_beat(input bit f, input bit l);
        int t = 0;
        scan_vld = 1; scan_fire = f; scan_last = l;
        while (!scan_rdy && t < 200) begin @(negedge clk); t++; end
        total++;
        if (!scan_rdy) $display("FAIL scan_accept_timeout: scan_rdy=%b after %0d cycles, need 1", scan_rdy, t);
        else pass++;
        @(negedge clk);
        scan_vld = 0; scan_fire = 0; scan_last = 0;
    endtask

    task automatic wait_pkts(input int n);
        int t = 0;
        while (pd.size() < n && t < 300) begin @(negedge clk); t++; end
        total++;
        if (pd.size() < n) $display("FAIL pkt_timeout: got %0d packets, need %0d", pd.size(), n);
        else pass++;
    endtask

    task automatic start_dump(input logic [NNW-1:0] len);
        rd_len = len; rd_req = 1;
        @(negedge clk);
        rd_req = 0;
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        repeat (2) @(negedge clk);
        total++; if (spk_out_vld !== 1'b0) $display("FAIL rst_vld: got %b need 0", spk_out_vld); else pass++;
        total++; if (spk_out_data !== 24'h0) $display("FAIL rst_data: got %h need 000000", spk_out_data); else pass++;
        total++; if (spk_out_type !== 3'b000) $display("FAIL rst_type: got %b need 000", spk_out_type); else pass++;
        total++; if (soma_rd_en !== 1'b0) $display("FAIL rst_rd_en: got %b need 0", soma_rd_en); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b need 0", busy); else pass++;
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic test_single_fire();
        clear_log();
        x_out = 4; y_out = 4; spk_out_rdy = 1;
        for (int i = 0; i < 16; i++) send_beat(i == 6, i == 15);
        wait_pkts(1);
        repeat (10) @(negedge clk);
        total++; if (pd.size() != 1) $display("FAIL single_count: got %0d need 1", pd.size()); else pass++;
        total++; if (pd[0] !== 24'h000102) $display("FAIL single_data: got %h need 000102", pd[0]); else pass++;
        total++; if (pt[0] !== 3'b000) $display("FAIL single_type: got %b need 000", pt[0]); else pass++;
        total++; if (busy !== 1'b0) $display("FAIL single_busy: got %b need 0", busy); else pass++;
    endtask

    task automatic test_z_wrap();
        clear_log();
        x_out = 2; y_out = 2;
        for (int i = 0; i < 6; i++) send_beat(i == 5, i == 5);
        for (int i = 0; i < 3; i++) send_beat(i == 0, i == 2);
        wait_pkts(2);
        total++; if (pd[0] !== 24'h010001) $display("FAIL zwrap_data: got %h need 010001", pd[0]); else pass++;
        total++; if (pd[1] !== 24'h000000) $display("FAIL zwrap_after_last: got %h need 000000", pd[1]); else pass++;
    endtask

    task automatic test_backpressure();
        logic [SW-1:0] exp;
        clear_log();
        x_out = 4; y_out = 4; spk_out_rdy = 0;
        for (int i = 0; i < 8; i++) send_beat(1, 0);
        scan_vld = 1; scan_fire = 1;
        repeat (3) @(negedge clk);
        total++; if (scan_rdy !== 1'b0) $display("FAIL bp_full_rdy: got %b need 0", scan_rdy); else pass++;
        total++; if (spk_out_vld !== 1'b1) $display("FAIL bp_vld_held: got %b need 1", spk_out_vld); else pass++;
        total++; if (spk_out_data !== 24'h000000) $display("FAIL bp_head_stable: got %h need 000000", spk_out_data); else pass++;
        total++; if (pd.size() != 0) $display("FAIL bp_no_xfer: got %0d need 0", pd.size()); else pass++;
        spk_out_rdy = 1;
        send_beat(1, 0);
        send_beat(1, 1);
        wait_pkts(10);
        repeat (20) @(negedge clk);
        total++; if (pd.size() != 10) $display("FAIL bp_count: got %0d need 10", pd.size()); else pass++;
        for (int i = 0; i < 10; i++) begin
            exp = {8'd0, 8'(i / 4), 8'(i % 4)};
            total++; if (pd[i] !== exp) $display("FAIL bp_order[%0d]: got %h need %h", i, pd[i], exp); else pass++;
        end
    endtask

    task automatic test_dump();
        clear_log();
        spk_out_rdy = 1;
        start_dump(3);
        wait_pkts(3);
        total++; if (busy !== 1'b0) $display("FAIL dump_busy: got %b need 0", busy); else pass++;
        total++; if (pd[0] !== 24'h100 || pt[0] !== 3'b001) $display("FAIL dump_w0: got %h/%b need 000100/001", pd[0], pt[0]); else pass++;
        total++; if (pd[1] !== 24'h101 || pt[1] !== 3'b001) $display("FAIL dump_w1: got %h/%b need 000101/001", pd[1], pt[1]); else pass++;
        total++; if (pd[2] !== 24'h102 || pt[2] !== 3'b010) $display("FAIL dump_w2: got %h/%b need 000102/010", pd[2], pt[2]); else pass++;
        total++; if (ra.size() != 3 || ra[0] !== 12'd0 || ra[1] !== 12'd1 || ra[2] !== 12'd2)
            $display("FAIL dump_addr: got n=%0d %h %h %h need 3 000 001 002", ra.size(), ra[0], ra[1], ra[2]); else pass++;
        total++; if (pc[2] - pc[1] != 3) $display("FAIL dump_rate: got %0d cycles need 3", pc[2] - pc[1]); else pass++;
    endtask

    task automatic test_len_zero();
        clear_log();
        start_dump(0);
        wait_pkts(1);
        repeat (10) @(negedge clk);
        total++; if (pd.size() != 1 || pd[0] !== 24'h100 || pt[0] !== 3'b010)
            $display("FAIL len0: got n=%0d %h/%b need 1 000100/010", pd.size(), pd[0], pt[0]); else pass++;
    endtask

    task automatic test_drain_before_dump();
        bit leak = 0;
        int t = 0;
        clear_log();
        x_out = 4; y_out = 4; spk_out_rdy = 0;
        send_beat(1, 0);
        send_beat(1, 1);
        start_dump(1);
        @(negedge clk);
        total++; if (scan_rdy !== 1'b0) $display("FAIL drain_scan_rdy: got %b need 0", scan_rdy); else pass++;
        total++; if (soma_rd_en !== 1'b0) $display("FAIL drain_early_rd: got %b need 0", soma_rd_en); else pass++;
        spk_out_rdy = 1;
        while (pd.size() < 3 && t < 300) begin
            if (scan_rdy) leak = 1;
            @(negedge clk); t++;
        end
        total++; if (pd.size() != 3) $display("FAIL drain_count: got %0d need 3", pd.size()); else pass++;
        total++; if (pd[0] !== 24'h0 || pd[1] !== 24'h1 || pt[0] !== 3'b000 || pt[1] !== 3'b000)
            $display("FAIL drain_spikes: got %h %h need 000000 000001 as SPIKE", pd[0], pd[1]); else pass++;
        total++; if (pt[2] !== 3'b010 || pd[2] !== 24'h100) $display("FAIL drain_data: got %h/%b need 000100/010", pd[2], pt[2]); else pass++;
        total++; if (rc.size() == 0 || rc[0] <= pc[1]) $display("FAIL drain_order: rd cycle %0d, last spike cycle %0d", rc.size() ? rc[0] : -1, pc[1]); else pass++;
        total++; if (leak) $display("FAIL drain_rdy_leak: scan_rdy went 1 during dump, need 0"); else pass++;
        total++; if (scan_rdy !== 1'b1) $display("FAIL drain_rdy_after: got %b need 1", scan_rdy); else pass++;
    endtask

    task automatic test_reset_mid_dump();
        clear_log();
        spk_out_rdy = 1;
        start_dump(5);
        wait_pkts(2);
        rst_n = 0;
        #1;
        total++; if (spk_out_vld !== 1'b0 || spk_out_data !== 24'h0 || soma_rd_en !== 1'b0 || busy !== 1'b0)
            $display("FAIL rstmid_outputs: got vld=%b data=%h rd=%b busy=%b need all 0", spk_out_vld, spk_out_data, soma_rd_en, busy); else pass++;
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (20) @(negedge clk);
        total++; if (pd.size() != 2) $display("FAIL rstmid_count: got %0d need 2", pd.size()); else pass++;
        total++; if (pt[1] !== 3'b001) $display("FAIL rstmid_type: got %b need 001", pt[1]); else pass++;
        total++; if (busy !== 1'b0 || scan_rdy !== 1'b1) $display("FAIL rstmid_idle: got busy=%b rdy=%b need 0 1", busy, scan_rdy); else pass++;
    endtask

    initial begin
        test_reset();
        test_single_fire();
        test_z_wrap();
        test_backpressure();
        test_dump();
        test_len_zero();
        test_drain_before_dump();
        test_reset_mid_dump();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
